button_event_encoder: RTL and testbench

BUTTON_EVENT_ENCODER -- requirements
Module: button_event_encoder

---
 rtl/lock_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 48 ++++
 rtl/button_event_encoder.sv | 107 ++++++++++
 tb/tb_button_event_encoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared event encoding for the lock front end: event codes, button indices
// and the priority rule used when several buttons settle on the same edge.
package lock_pkg;

  typedef enum logic [2:0] {
    EV_NONE    = 3'd0,
    EV_ZERO    = 3'd1,
    EV_ONE     = 3'd2,
    EV_CONFIRM = 3'd3,
    EV_CLEAR   = 3'd4,
    EV_SELECT  = 3'd5
  } ev_code_t;

  localparam int NUM_BTNS    = 5;
  localparam int BTN_ZERO    = 0;
  localparam int BTN_ONE     = 1;
  localparam int BTN_CONFIRM = 2;
  localparam int BTN_CLEAR   = 3;
  localparam int BTN_SELECT  = 4;

  // clear > confirm > select > one > zero; the losers are simply dropped.
  function automatic ev_code_t priority_encode(input logic [NUM_BTNS-1:0] rise);
    ev_code_t code;
    if (rise[BTN_CLEAR])        code = EV_CLEAR;
    else if (rise[BTN_CONFIRM]) code = EV_CONFIRM;
    else if (rise[BTN_SELECT])  code = EV_SELECT;
    else if (rise[BTN_ONE])     code = EV_ONE;
    else if (rise[BTN_ZERO])    code = EV_ZERO;
    else                        code = EV_NONE;
    return code;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, stability counter and filtered level.
// rise pulses on the edge where the filtered level goes 0->1.
module btn_debounce #(
  parameter int STABLE_CYCLES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam logic [3:0] LAST_COUNT = 4'(STABLE_CYCLES - 1);

  logic       s1_reg;
  logic       s2_reg;
  logic       filtered_reg;
  logic [3:0] count_reg;
  logic       differs;
  logic       settle;

  always_comb begin
    differs = (s2_reg != filtered_reg);
    settle  = differs && (count_reg == LAST_COUNT);
    rise    = settle && s2_reg;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      filtered_reg <= 1'b0;
      count_reg    <= 4'd0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
      // The count is cleared both on acceptance and whenever s2 agrees again.
      if (settle) begin
        filtered_reg <= s2_reg;
        count_reg    <= 4'd0;
      end else if (differs) begin
        count_reg <= count_reg + 4'd1;
      end else begin
        count_reg <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/button_event_encoder.sv
// Debounces five lock buttons and queues press events in a small FIFO.
// Build option BTN_FLUSH_ON_CLEAR_EN: a clear event flushes the queue.
module button_event_encoder
  import lock_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enter0,
  input  logic                          enter1,
  input  logic                          confirm,
  input  logic                          clear,
  input  logic                          algorithm_select_mode,
  output logic                          ev_valid,
  output logic [2:0]                    ev_code,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [NUM_BTNS-1:0] raw_btn;
  logic [NUM_BTNS-1:0] rise;

  assign raw_btn = {algorithm_select_mode, clear, confirm, enter1, enter0};

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .STABLE_CYCLES(STABLE_CYCLES)
      ) u_debounce (
        .clock(clock),
        .reset(reset),
        .raw  (raw_btn[gi]),
        .rise (rise[gi])
      );
    end
  endgenerate

  ev_code_t        mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg,  count_next;
  logic            overflow_reg, overflow_next;
  ev_code_t        push_code;
  logic            push, pop, full, empty, flush, accept;

  always_comb begin
    push_code     = priority_encode(rise);
    push          = (push_code != EV_NONE);
    empty         = (count_reg == '0);
    full          = (count_reg == CW'(FIFO_DEPTH));
    pop           = ev_ready && !empty;
`ifdef BTN_FLUSH_ON_CLEAR_EN
    flush         = push && (push_code == EV_CLEAR);
`else
    flush         = 1'b0;
`endif
    accept        = push && (!full || pop || flush);
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (pop)    rd_ptr_next = rd_ptr_reg + PW'(1);
    if (accept) wr_ptr_next = wr_ptr_reg + PW'(1);

    // A flush makes the freshly written slot the new head, discarding the rest.
    if (flush) begin
      rd_ptr_next = wr_ptr_reg;
      count_next  = CW'(1);
    end else begin
      count_next = count_reg + CW'(accept) - CW'(pop);
    end

    if (push && !accept) overflow_next = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage carries no reset; stale contents are masked by the occupancy.
  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr_reg] <= push_code;
  end

  assign ev_valid = !empty;
  assign ev_code  = empty ? 3'(EV_NONE) : 3'(mem[rd_ptr_reg]);
  assign ev_count = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_button_event_encoder.sv
// Directed self-checking bench for button_event_encoder (STABLE_CYCLES=3, depth 4).
// Honors BTN_FLUSH_ON_CLEAR_EN to choose the expected clear behaviour.
module tb_button_event_encoder;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_ZERO    = 3'd1;
  localparam logic [2:0] E_ONE     = 3'd2;
  localparam logic [2:0] E_CONFIRM = 3'd3;
  localparam logic [2:0] E_CLEAR   = 3'd4;
  localparam logic [2:0] E_SELECT  = 3'd5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enter0 = 1'b0, enter1 = 1'b0, confirm = 1'b0, clear = 1'b0;
  logic       algorithm_select_mode = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic [2:0] ev_count;
  logic       overflow;

  int tests_run = 0;
  int failed    = 0;

  button_event_encoder #(
    .STABLE_CYCLES(3),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .enter0               (enter0),
    .enter1               (enter1),
    .confirm              (confirm),
    .clear                (clear),
    .algorithm_select_mode(algorithm_select_mode),
    .ev_valid             (ev_valid),
    .ev_code              (ev_code),
    .ev_ready             (ev_ready),
    .ev_count             (ev_count),
    .overflow             (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: enter0 = v;
      1: enter1 = v;
      2: confirm = v;
      3: clear = v;
      default: algorithm_select_mode = v;
    endcase
  endtask

  // Hold long enough to be accepted, then leave time for the release to settle.
  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    step(4);
    set_btn(idx, 1'b0);
    step(8);
  endtask

  task automatic pop_expect(input string tag, input logic [2:0] exp);
    check({tag, "_valid"}, ev_valid, 1);
    check({tag, "_code"}, ev_code, exp);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    step(2);
    check("rst_valid", ev_valid, 0);
    check("rst_code", ev_code, E_NONE);
    check("rst_count", ev_count, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b1;
    step(2);

    // enter1 held 3 samples: event appears after E0+4
    enter1 = 1'b1;
    step(3);
    enter1 = 1'b0;
    step(1);
    check("t1_valid_e3", ev_valid, 0);
    step(1);
    check("t1_valid_e4", ev_valid, 1);
    check("t1_code", ev_code, E_ONE);
    check("t1_count", ev_count, 1);
    step(10);
    check("t1_count_hold", ev_count, 1);
    pop_expect("t1_pop", E_ONE);
    check("t1_count_after_pop", ev_count, 0);

    // Short glitch on enter0 is rejected
    enter0 = 1'b1;
    step(2);
    enter0 = 1'b0;
    step(10);
    check("t2_valid", ev_valid, 0);
    check("t2_count", ev_count, 0);

    // Five presses into a depth-4 queue: last one dropped
    press(3);
    press(0);
    press(1);
    press(2);
    press(4);
    check("t3_count", ev_count, 4);
    check("t3_overflow", overflow, 1);
    pop_expect("t3_pop0", E_CLEAR);
    pop_expect("t3_pop1", E_ZERO);
    pop_expect("t3_pop2", E_ONE);
    pop_expect("t3_pop3", E_CONFIRM);
    check("t3_count_empty", ev_count, 0);
    check("t3_overflow_sticky", overflow, 1);

    // ev_ready while empty does nothing
    ev_ready = 1'b1;
    step(2);
    ev_ready = 1'b0;
    check("t_empty_count", ev_count, 0);
    check("t_empty_valid", ev_valid, 0);
    check("t_empty_code", ev_code, E_NONE);

    // confirm and enter1 rising together: only confirm queued
    confirm = 1'b1;
    enter1  = 1'b1;
    step(4);
    confirm = 1'b0;
    enter1  = 1'b0;
    step(8);
    check("t4_count", ev_count, 1);
    pop_expect("t4_pop", E_CONFIRM);
    check("t4_count_empty", ev_count, 0);
    check("t4_overflow", overflow, 1);

    // 1,0,1 then clear
    press(1);
    press(0);
    press(1);
    check("t5_count3", ev_count, 3);
    press(3);
`ifdef BTN_FLUSH_ON_CLEAR_EN
    check("t5_count_flush", ev_count, 1);
    pop_expect("t5_pop_clear", E_CLEAR);
`else
    check("t5_count_noflush", ev_count, 4);
    pop_expect("t5_pop0", E_ONE);
    pop_expect("t5_pop1", E_ZERO);
    pop_expect("t5_pop2", E_ONE);
    pop_expect("t5_pop3", E_CLEAR);
`endif
    check("t5_count_empty", ev_count, 0);

    // Reset pulse with 3 queued and enter1 held across it
    press(1);
    press(0);
    press(1);
    check("t6_count3", ev_count, 3);
    enter1 = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("t6_count_rst", ev_count, 0);
    check("t6_valid_rst", ev_valid, 0);
    check("t6_code_rst", ev_code, E_NONE);
    check("t6_overflow_rst", overflow, 0);
    step(4);
    check("t6_valid_r4", ev_valid, 0);
    step(1);
    check("t6_valid_r5", ev_valid, 1);
    check("t6_code_r5", ev_code, E_ONE);
    step(10);
    check("t6_count_hold", ev_count, 1);
    enter1 = 1'b0;
    step(8);

    // Full queue: push and pop on the same edge keeps occupancy, no overflow
    press(0);
    press(1);
    press(0);
    check("t7_count_full", ev_count, 4);
    confirm = 1'b1;
    step(3);
    confirm = 1'b0;
    step(1);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    check("t7_count_after", ev_count, 4);
    check("t7_overflow", overflow, 0);
    step(8);
    pop_expect("t7_pop0", E_ZERO);
    pop_expect("t7_pop1", E_ONE);
    pop_expect("t7_pop2", E_ZERO);
    pop_expect("t7_pop3", E_CONFIRM);
    check("t7_count_empty", ev_count, 0);
    check("t7_select_unused", (E_SELECT != E_NONE) ? overflow : 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
